fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter BUF_DEPTH, default 2, total credit: in-flight requests plus buffered instructions; the only supported value is 2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall_fetch  in  1  decode not accepting; hold the presented instruction.
REQ-006 redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  in  `WIDTH  redirect target address.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  `WIDTH  request address, word aligned.
REQ-010 imem_ready  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  in  1  read data valid; responses return in request order.
REQ-012 imem_rdata  in  `WIDTH  instruction word.
REQ-013 instr_fetch  out  `WIDTH  instruction presented to the decode pipeline register.
REQ-014 pc_fetch  out  `WIDTH  presented instruction address + 4 (PCPlus4).
REQ-015 fetch_valid  out  1  instr_fetch/pc_fetch carry a real instruction.

Function
REQ-016 Request pointer req_pc: a request is accepted when imem_req && imem_ready; on acceptance req_pc += 4 and the outstanding count increments.
REQ-017 imem_addr shall equal req_pc; imem_req shall be 1 iff outstanding + buffered < BUF_DEPTH, no redirect this cycle, and not in reset.
REQ-018 imem_req and imem_addr shall stay stable until accepted unless redirect_valid rises.
REQ-019 Each imem_rvalid decrements outstanding; if discard_cnt > 0 the word is dropped and discard_cnt decrements, otherwise the word is pushed into the 2-entry in-order buffer.
REQ-020 Head pointer head_pc tracks the address of the buffer head; fetch_valid = buffer non-empty.
REQ-021 fetch_valid=1: instr_fetch = head word, pc_fetch = head_pc + 4 (combinational from registered state, zero-cycle latency).
REQ-022 fetch_valid=0: instr_fetch = 32'h0000_0000 (NOP), pc_fetch = head_pc + 4.
REQ-023 Pop when fetch_valid && !stall_fetch && !redirect_valid; on pop head_pc += 4.
REQ-024 Simultaneous push and pop: count unchanged, ordering preserved; push into a full buffer cannot occur (credit rule).
REQ-025 Stall: buffer, head_pc, and outputs held; new requests continue only while credit remains.
REQ-026 Redirect (highest priority, overrides stall and pop): buffer cleared, req_pc and head_pc <= {redirect_pc[31:2],2'b00}, discard_cnt <= outstanding minus 1 if imem_rvalid this cycle, no push this cycle.
REQ-027 Redirect arriving while discard_cnt > 0: discard_cnt recomputed per REQ-026 (never lost, never double-counted).
REQ-028 Min latency from accepted request to fetch_valid = 1 cycle after imem_rvalid.
REQ-029 Counters saturate-free: outstanding, discard_cnt, and count each 2 bits wide, never exceeding BUF_DEPTH; exceeding is an assertion failure.

Reset
REQ-030 On rst, asynchronously: req_pc = head_pc = RESET_PC; buffer count, outstanding, and discard_cnt = 0.
REQ-031 During and after reset: fetch_valid = 0, instr_fetch = 0, imem_req = 0 until the first clock edge with rst low.
REQ-032 Reset mid-operation drops all buffered and in-flight words; responses arriving after reset while outstanding = 0 are ignored.

Structure
REQ-033 `WIDTH, RESET_PC default, and the NOP encoding reside in the shared defines.v.
REQ-034 The 2-entry FIFO (push, pop, clear, count, head data) is one sub-module, fetch_buffer; pointer and credit logic stay in fetch_unit.

Verification
REQ-035 Reset release, imem_ready=1, rvalid one cycle after each accept -> addresses 0x0,0x4,0x8 requested back-to-back; pc_fetch 0x4,0x8,0xC with fetch_valid.
REQ-036 stall_fetch held 3 cycles with buffer full -> imem_req=0, instr_fetch/pc_fetch unchanged; release pops in order, with no loss or duplication.
REQ-037 redirect_valid with redirect_pc=0x100 and 2 requests outstanding -> the next 2 rvalid words are dropped, the first delivered pc_fetch=0x104.
REQ-038 redirect_pc=0x203 -> imem_addr=0x200.
REQ-039 Redirect in the same cycle as rvalid and pop -> that word is dropped, discard_cnt=outstanding-1, head_pc=target.
REQ-040 rst asserted with 1 buffered and 1 outstanding -> fetch_valid=0 immediately; after release the first request goes to RESET_PC and the stale response is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: datapath width, reset vector default,
// the NOP encoding and word-alignment helper.
package fetch_unit_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WIDTH-1:0] NOP              = 32'h0000_0000;
    localparam logic [WIDTH-1:0] INSTR_BYTES      = 32'd4;

    localparam int unsigned FIFO_ENTRIES = 2;

    typedef logic [1:0] cnt_t;

    function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer: push at tail, pop at head, clear
// wins over everything. Head word is presented combinationally.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output cnt_t             count
);

    logic [WIDTH-1:0] mem_q [FIFO_ENTRIES];
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    logic             wr_ptr_q;
    logic             wr_ptr_d;
    cnt_t             count_q;
    cnt_t             count_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && (count_q == 2'd2) && !pop));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= 2'd2);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads under a credit limit,
// buffers in-order responses and presents them to decode with redirect support.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned      BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_fetch,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_fetch,
    output logic [WIDTH-1:0] pc_fetch,
    output logic             fetch_valid
);

    localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

    logic             started_q;
    logic [WIDTH-1:0] req_pc_q;
    logic [WIDTH-1:0] req_pc_d;
    logic [WIDTH-1:0] head_pc_q;
    logic [WIDTH-1:0] head_pc_d;
    cnt_t             outstanding_q;
    cnt_t             outstanding_d;
    cnt_t             discard_q;
    cnt_t             discard_d;

    cnt_t             buf_count;
    logic [WIDTH-1:0] buf_head;
    logic [WIDTH-1:0] redirect_target;
    logic [2:0]       credit_used;
    logic             accept;
    logic             rsp;
    logic             drop;
    logic             push;
    logic             pop;

    assign redirect_target = align_word(redirect_pc);

    assign fetch_valid = (buf_count != 2'd0);
    assign pop         = fetch_valid && !stall_fetch && !redirect_valid;

    // A pop this cycle frees its slot immediately so fetch can stream back-to-back.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count} - {2'b00, pop};
    assign imem_req    = started_q && !redirect_valid && (credit_used < CREDIT);
    assign imem_addr   = req_pc_q;
    assign accept      = imem_req && imem_ready;

    // Responses with nothing outstanding are stale (pre-reset) and ignored.
    assign rsp  = imem_rvalid && (outstanding_q != 2'd0);
    assign drop = rsp && (discard_q != 2'd0);
    assign push = rsp && !drop && !redirect_valid;

    assign instr_fetch = fetch_valid ? buf_head : NOP;
    assign pc_fetch    = head_pc_q + INSTR_BYTES;

    always_comb begin
        req_pc_d      = req_pc_q;
        head_pc_d     = head_pc_q;
        outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, rsp};
        discard_d     = discard_q - {1'b0, drop};
        if (redirect_valid) begin
            req_pc_d  = redirect_target;
            head_pc_d = redirect_target;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d = outstanding_q - {1'b0, rsp};
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + INSTR_BYTES;
            end
            if (pop) begin
                head_pc_d = head_pc_q + INSTR_BYTES;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q     <= 1'b0;
            req_pc_q      <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else begin
            started_q     <= 1'b1;
            req_pc_q      <= req_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (imem_rdata),
        .head_data (buf_head),
        .count     (buf_count)
    );

    a_outstanding_range: assert property (@(posedge clk) disable iff (rst)
        {1'b0, outstanding_q} <= CREDIT);

    a_discard_range: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, outstanding_q} + {1'b0, buf_count}) <= CREDIT);

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ready) |=> (redirect_valid || (imem_req && $stable(imem_addr))));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based model of
// the credit, discard and buffering rules, plus an in-order memory responder.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_fetch;
    logic [31:0] pc_fetch;
    logic        fetch_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_fetch    (instr_fetch),
        .pc_fetch       (pc_fetch),
        .fetch_valid    (fetch_valid)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Memory side and observation logs.
    logic [31:0] mem_q[$];
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_w[$];

    // Reference model: words waiting for decode, and one flag per request in flight.
    logic [31:0] m_buf[$];
    bit          m_stale[$];
    logic [31:0] m_req_pc;
    logic [31:0] m_head_pc;
    bit          m_started;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h5A1E};
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc.delete();
        deliv_pc.delete();
        deliv_w.delete();
    endtask

    // Entered and left at posedge+1. rv_mode: 0 none, 1 respond if pending, 2 forced stale.
    task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                        input bit ready, input int rv_mode);
        bit m_fv;
        bit m_pop;
        bit m_req;
        int used;
        stall_fetch    = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ready     = ready;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if ((rv_mode == 1 && mem_q.size() > 0) || rv_mode == 2) begin
            imem_rvalid = 1'b1;
            if (mem_q.size() > 0) imem_rdata = mem_q.pop_front();
        end
        @(negedge clk);
        m_fv  = (m_buf.size() > 0);
        m_pop = m_fv && !stall && !redir;
        used  = m_stale.size() + m_buf.size() - (m_pop ? 1 : 0);
        m_req = m_started && !redir && (used < 2);
        check_eq("imem_req", 32'(imem_req), 32'(m_req));
        check_eq("imem_addr", imem_addr, m_req_pc);
        check_eq("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        check_eq("instr_fetch", instr_fetch, m_fv ? m_buf[0] : 32'h0);
        check_eq("pc_fetch", pc_fetch, m_head_pc + 32'd4);

        if (imem_req && imem_ready) begin
            mem_q.push_back(word_of(imem_addr));
            acc_q.push_back(imem_addr);
            acc_cyc.push_back(cyc);
        end
        if (fetch_valid && !stall && !redir) begin
            deliv_pc.push_back(pc_fetch);
            deliv_w.push_back(instr_fetch);
        end

        if (m_pop) begin
            void'(m_buf.pop_front());
            m_head_pc += 32'd4;
        end
        if (imem_rvalid && m_stale.size() > 0) begin
            if (!m_stale.pop_front() && !redir) m_buf.push_back(imem_rdata);
        end
        if (m_req && ready) begin
            m_stale.push_back(1'b0);
            m_req_pc += 32'd4;
        end
        if (redir) begin
            m_buf.delete();
            foreach (m_stale[i]) m_stale[i] = 1'b1;
            m_req_pc  = {rpc[31:2], 2'b00};
            m_head_pc = {rpc[31:2], 2'b00};
        end
        m_started = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, releases at posedge+1.
    task automatic apply_reset(input bit flush);
        #3 rst = 1'b1;
        #1;
        check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check_eq("rst_instr", instr_fetch, 32'd0);
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        stall_fetch    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        m_buf.delete();
        m_stale.delete();
        m_req_pc  = 32'h0;
        m_head_pc = 32'h0;
        m_started = 1'b0;
        if (flush) mem_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        stall_fetch    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset(1'b1);

        // Streaming fetch with single-cycle memory.
        clear_logs();
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        check_eq("stream_addr0", q_at(acc_q, 0), 32'h0);
        check_eq("stream_addr1", q_at(acc_q, 1), 32'h4);
        check_eq("stream_addr2", q_at(acc_q, 2), 32'h8);
        check_eq("stream_b2b", 32'((acc_cyc.size() >= 3) ? (acc_cyc[2] - acc_cyc[0]) : 0), 32'd2);
        check_eq("stream_pc0", q_at(deliv_pc, 0), 32'h4);
        check_eq("stream_pc1", q_at(deliv_pc, 1), 32'h8);
        check_eq("stream_pc2", q_at(deliv_pc, 2), 32'hC);
        check_eq("stream_w0", q_at(deliv_w, 0), word_of(32'h0));

        // Stall with a full buffer.
        apply_reset(1'b1);
        clear_logs();
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1, 1);
            check_eq("stall_req", 32'(imem_req), 32'd0);
            check_eq("stall_instr", instr_fetch, word_of(32'h0));
            check_eq("stall_pc", pc_fetch, 32'h4);
        end
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_rel_pc", q_at(deliv_pc, i), 32'(4 * (i + 1)));
            check_eq("stall_rel_w", q_at(deliv_w, i), word_of(32'(4 * i)));
        end

        // Redirect with two requests outstanding.
        apply_reset(1'b1);
        clear_logs();
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 0);
        check_eq("redir_addr", imem_addr, 32'h100);
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        check_eq("redir_acc", q_at(acc_q, 2), 32'h100);
        check_eq("redir_pc0", q_at(deliv_pc, 0), 32'h104);
        check_eq("redir_w0", q_at(deliv_w, 0), word_of(32'h100));

        // Misaligned redirect target.
        step(1'b0, 1'b1, 32'h203, 1'b1, 1);
        check_eq("align_addr", imem_addr, 32'h200);
        check_eq("align_pc", pc_fetch, 32'h204);
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1, 1);

        // Redirect together with a response and a would-be pop.
        apply_reset(1'b1);
        clear_logs();
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        step(1'b0, 1'b1, 32'h300, 1'b1, 1);
        check_eq("rvpop_valid", 32'(fetch_valid), 32'd0);
        check_eq("rvpop_pc", pc_fetch, 32'h304);
        check_eq("rvpop_addr", imem_addr, 32'h300);
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        check_eq("rvpop_dpc", q_at(deliv_pc, 0), 32'h304);
        check_eq("rvpop_dw", q_at(deliv_w, 0), word_of(32'h300));

        // Reset with one buffered word and one request in flight.
        apply_reset(1'b1);
        clear_logs();
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1, 1);
        apply_reset(1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 2);
        mem_q.delete();
        clear_logs();
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        check_eq("rst_acc0", q_at(acc_q, 0), 32'h0);
        check_eq("rst_dpc0", q_at(deliv_pc, 0), 32'h4);
        check_eq("rst_dw0", q_at(deliv_w, 0), word_of(32'h0));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset(1'b1);
            end else begin
                step(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 7),
                     32'($urandom_range(0, 32'hFFFF)), ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 9) < 6) ? 1 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
